fifo_sync: RTL
==============

Name: fifo_sync

Overview:
- Single-clock, parametrised successor to the dual-clock FIFO.
- Valid/ready handshakes on both ends, first-word-fall-through read, exact occupancy count, programmable almost-full/almost-empty thresholds, flush, and sticky overflow/underflow flags.
- Placed between streaming producers and consumers in the same clock domain. Storage is inferred as iCE40 4kb RAM blocks.

Parameters:
- n, 8: data width in bits; 2, 4, 8 or 16.
- m, 512: depth in entries; power of 2, at least 4.
- af, m-4: almost_full threshold; almost_full=1 when level>=af; 1<=af<=m.
- ae, 4: almost_empty threshold; almost_empty=1 when level<=ae; 0<=ae<m.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous clear of contents; flags are kept.
- wr_data  in  n  write data.
- wr_valid  in  1  producer offers wr_data.
- wr_ready  out  1  FIFO can accept; equals !full.
- rd_data  out  n  oldest entry; 0 when empty.
- rd_valid  out  1  rd_data holds a valid entry; equals level!=0.
- rd_ready  in  1  consumer takes rd_data.
- level  out  clog2(m)+1  stored entries, 0..m.
- status  out  4  0000 empty, 0001 <=25%, 0011 <=50%, 0101 <=75%, 0111 <100%, 1111 full.
- almost_full  out  1  level>=af.
- almost_empty  out  1  level<=ae.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (rst_n=0 at posedge):
  - level=0, all pointers 0.
  - rd_data=0, rd_valid=0, wr_ready=1, status=0000, almost_empty=1, almost_full=(af==0 ? 1 : 0), which is 0 for legal af.
  - overflow=0, underflow=0.
  - Reset overrides every other input in that cycle, including an in-progress write or read.
- Handshake:
  - Write accepted when wr_valid&&wr_ready at posedge.
  - Read accepted when rd_valid&&rd_ready at posedge.
  - wr_ready and rd_valid depend only on registered state, never combinationally on wr_valid or rd_ready.
- Latency:
  - A write accepted at edge k into an empty FIFO gives rd_valid=1 and rd_data=that word after edge k (valid in cycle k+1).
  - A read accepted at edge k presents the next entry after edge k, with no bubble.
  - Sustained throughput is 1 write and 1 read per cycle.
  - Implementation: RAM plus a registered output stage with prefetch. level counts the output stage.
- Level arithmetic:
  - level_next = level + write_acc - read_acc.
  - Pointers are clog2(m) bits and wrap modulo m.
  - Simultaneous accepted read and write leaves level unchanged.
- Full (level==m): wr_ready=0 even if a read is accepted in the same cycle; the write is not accepted.
- Empty (level==0): rd_valid=0 and rd_data=0. A write in the same cycle is accepted; its data is not readable in that same cycle.
- Sticky flags:
  - overflow sets on wr_valid&&!wr_ready.
  - underflow sets on rd_ready&&!rd_valid.
  - Both clear only on reset.
- flush=1 at posedge:
  - level=0, pointers=0, rd_data=0, rd_valid=0.
  - Any write or read presented in that cycle is dropped and does not set flags.
  - flush has lower priority than reset.
- Derived outputs: status, almost_full and almost_empty are derived from the registered level and update in the same cycle as level.

Optional Feature:
- Macro: FIFO_PEAK_EN.
- Defined:
  - Adds output port peak [clog2(m)+1], the high-watermark of level.
  - Adds input peak_clr [1].
  - peak updates to level_next whenever level_next>peak.
  - peak resets to 0 on rst_n=0.
  - peak_clr=1 at posedge loads peak with the current level.
  - flush does not clear peak.
- Undefined: neither port exists and no watermark logic is synthesised.

Test Plan (n=8, m=16, af=12, ae=2):
- Reset, then write 0x01..0x10 with rd_ready=0 → level 1..16, almost_empty falls when level=3, almost_full rises at level=12, status=1111 and wr_ready=0 at 16, overflow=0.
- Same full FIFO, wr_valid=1 for one more cycle → no write accepted, level stays 16, overflow=1 and stays 1; rd_ready=1 drains 0x01..0x10 in order, one per cycle.
- Empty FIFO, write 0xA5 at edge k → rd_valid=1, rd_data=0xA5 in cycle k+1; rd_ready=1 → rd_data=0, rd_valid=0, level=0.
- Level 8, wr_valid=rd_ready=1 for 20 cycles with incrementing data → level stays 8, output order preserved across pointer wrap, no flags set.
- Level 16 with read and write both asserted → only the read is accepted, level=15; next cycle wr_ready=1.
- Level 5, flush=1 with wr_valid=1 → level=0, rd_data=0, overflow and underflow unchanged; then rst_n=0 mid-burst → all outputs at reset values the following cycle.

Source files
------------

// File: rtl/fifo_sync.sv
// Single-clock FWFT FIFO: RAM plus registered output stage, exact level.
// Define FIFO_PEAK_EN to add the peak/peak_clr high-watermark tracker.
module fifo_sync #(
  parameter int n  = 8,
  parameter int m  = 512,
  parameter int af = m - 4,
  parameter int ae = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [n-1:0]      wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [n-1:0]      rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
`ifdef FIFO_PEAK_EN
  input  logic              peak_clr,
  output logic [$clog2(m):0] peak,
`endif
  output logic [$clog2(m):0] level,
  output logic [3:0]        status,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = $clog2(m);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] LM  = LW'(m);
  localparam logic [LW-1:0] LAF = LW'(af);
  localparam logic [LW-1:0] LAE = LW'(ae);
  localparam logic [LW-1:0] Q1  = LW'(m / 4);
  localparam logic [LW-1:0] Q2  = LW'(m / 2);
  localparam logic [LW-1:0] Q3  = LW'((3 * m) / 4);

  logic [n-1:0]  mem [m];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [n-1:0]  out_q;
  logic          out_v;
  logic [LW-1:0] lvl;
  logic [LW-1:0] lvl_nxt;
  logic [LW-1:0] ram_cnt;
  logic          ovf;
  logic          unf;

  logic wr_acc;
  logic rd_acc;
  logic ram_empty;
  logic take;
  logic bypass;
  logic ram_wr;
  logic ram_rd;

  assign wr_ready  = (lvl != LM);
  assign rd_valid  = out_v;
  assign rd_data   = out_q;
  assign level     = lvl;
  assign overflow  = ovf;
  assign underflow = unf;

  assign wr_acc    = wr_valid && wr_ready && !flush;
  assign rd_acc    = rd_ready && out_v && !flush;
  assign ram_cnt   = lvl - {{AW{1'b0}}, out_v};
  assign ram_empty = (ram_cnt == '0);
  assign take      = !out_v || rd_acc;
  assign bypass    = wr_acc && ram_empty && take;
  assign ram_wr    = wr_acc && !bypass;
  assign ram_rd    = take && !ram_empty && !flush;

  // Next occupancy from accepted handshakes
  always_comb begin
    lvl_nxt = lvl;
    unique case ({wr_acc, rd_acc})
      2'b10:   lvl_nxt = lvl + 1'b1;
      2'b01:   lvl_nxt = lvl - 1'b1;
      default: lvl_nxt = lvl;
    endcase
  end

  // Storage array, written when the word does not go straight to output
  always_ff @(posedge clk) begin
    if (ram_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers, output stage with prefetch, level and sticky flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      out_q  <= '0;
      out_v  <= 1'b0;
      lvl    <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      out_q  <= '0;
      out_v  <= 1'b0;
      lvl    <= '0;
    end else begin
      if (wr_valid && !wr_ready) ovf <= 1'b1;
      if (rd_ready && !out_v)    unf <= 1'b1;
      lvl <= lvl_nxt;
      if (ram_wr) wr_ptr <= wr_ptr + 1'b1;
      if (ram_rd) rd_ptr <= rd_ptr + 1'b1;
      if (take) begin
        if (!ram_empty) begin
          out_q <= mem[rd_ptr];
          out_v <= 1'b1;
        end else if (bypass) begin
          out_q <= wr_data;
          out_v <= 1'b1;
        end else begin
          out_q <= '0;
          out_v <= 1'b0;
        end
      end
    end
  end

  // Coarse fill indication and thresholds from registered level
  always_comb begin
    status = 4'b0111;
    if (lvl == '0)      status = 4'b0000;
    else if (lvl == LM) status = 4'b1111;
    else if (lvl <= Q1) status = 4'b0001;
    else if (lvl <= Q2) status = 4'b0011;
    else if (lvl <= Q3) status = 4'b0101;
    almost_full  = (lvl >= LAF);
    almost_empty = (lvl <= LAE);
  end

`ifdef FIFO_PEAK_EN
  // High-watermark of level; clear reloads the present level
  always_ff @(posedge clk) begin
    if (!rst_n)              peak <= '0;
    else if (peak_clr)       peak <= lvl;
    else if (lvl_nxt > peak) peak <= lvl_nxt;
  end
`endif

endmodule
